// File: rtl/serial_adder_pkg.sv
// Shared definitions for the serial adder: FSM state encoding and
// elaboration-time helpers that derive the chunk count and counter width.
package serial_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Number of RUN cycles needed to cover all WIDTH bits.
  function automatic int calc_k(input int width, input int bpc);
    return (bpc > 0) ? (width / bpc) : 1;
  endfunction

  // Chunk counter width: clog2(K), never narrower than one bit.
  function automatic int calc_cnt_w(input int width, input int bpc);
    int k;
    k = calc_k(width, bpc);
    return (k > 1) ? $clog2(k) : 1;
  endfunction

  // Legal configuration: positive width, chunk size dividing the width.
  function automatic bit cfg_ok(input int width, input int bpc);
    return (width >= 1) && (bpc >= 1) && (bpc <= width) && ((width % bpc) == 0);
  endfunction

endpackage

// File: rtl/full_adder_bit.sv
// One-bit full adder cell; chained to form the per-cycle chunk slice.
module full_adder_bit (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));

endmodule

// File: rtl/serial_adder_n.sv
// Multi-cycle adder/subtractor: processes BITS_PER_CYCLE bits per clock,
// LSB chunk first, through one ripple slice and a registered carry.
// Results (s/cout/ovf) update together with a one-cycle done pulse.
module serial_adder_n
  import serial_adder_pkg::*;
#(
  parameter int WIDTH          = 8,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic             ovf
);

  localparam int BPC   = BITS_PER_CYCLE;
  localparam int K     = calc_k(WIDTH, BPC);
  localparam int CNT_W = calc_cnt_w(WIDTH, BPC);
  localparam int SR_W  = (K > 1) ? (WIDTH - BPC) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(K - 1);

  if (!cfg_ok(WIDTH, BPC)) begin : g_cfg_err
    $error("serial_adder_n: BITS_PER_CYCLE must divide WIDTH (both >= 1)");
  end

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               carry_q, carry_d;
  logic [WIDTH-1:0]   a_sr_q, a_sr_d;
  logic [WIDTH-1:0]   b_sr_q, b_sr_d;
  logic [SR_W-1:0]    sum_sr_q, sum_sr_d;
  logic [WIDTH-1:0]   s_q, s_d;
  logic               cout_q, cout_d;
  logic               ovf_q, ovf_d;

  // Chunk slice: ripple chain of full adders fed by the low chunk of A/B.
  logic [BPC:0]       chain_c;
  logic [BPC-1:0]     chunk_sum;
  logic [WIDTH-1:0]   sum_full;

  assign chain_c[0] = carry_q;

  for (genvar i = 0; i < BPC; i++) begin : g_slice
    full_adder_bit u_fa (
      .a  (a_sr_q[i]),
      .b  (b_sr_q[i]),
      .ci (chain_c[i]),
      .s  (chunk_sum[i]),
      .co (chain_c[i+1])
    );
  end

  // Completed sum view: new chunk on top of the bits already accumulated.
  if (K > 1) begin : g_multi
    assign sum_full = {chunk_sum, sum_sr_q};
  end else begin : g_single
    assign sum_full = chunk_sum;
  end

  // Next-state and datapath update; chain_c[BPC-1] is the carry into the
  // chunk's top bit, which on the last chunk is the carry into the MSB.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    carry_d  = carry_q;
    a_sr_d   = a_sr_q;
    b_sr_d   = b_sr_q;
    sum_sr_d = sum_sr_q;
    s_d      = s_q;
    cout_d   = cout_q;
    ovf_d    = ovf_q;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          a_sr_d  = a;
          b_sr_d  = b ^ {WIDTH{sub}};
          carry_d = sub ? 1'b1 : cin;
          cnt_d   = '0;
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        a_sr_d   = a_sr_q >> BPC;
        b_sr_d   = b_sr_q >> BPC;
        sum_sr_d = sum_full[WIDTH-1 -: SR_W];
        carry_d  = chain_c[BPC];
        cnt_d    = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_CNT) begin
          s_d     = sum_full;
          cout_d  = chain_c[BPC];
          ovf_d   = chain_c[BPC-1] ^ chain_c[BPC];
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Control and result registers; reset aborts any operation in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      s_q     <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      s_q     <= s_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  // Operand and partial-sum shift registers; contents are don't-care
  // outside RUN, so they carry no reset.
  always_ff @(posedge clk) begin
    a_sr_q   <= a_sr_d;
    b_sr_q   <= b_sr_d;
    sum_sr_q <= sum_sr_d;
  end

  assign busy = (state_q == RUN);
  assign done = (state_q == DONE);
  assign s    = s_q;
  assign cout = cout_q;
  assign ovf  = ovf_q;

endmodule

// File: tb/tb_serial_adder_n.sv
// Bench for serial_adder_n: two 8-bit instances (1 and 4 bits per cycle)
// with cycle-exact timing checks, plus a 4-bit instance swept exhaustively.
module tb_serial_adder_n;

  typedef struct packed {
    logic [7:0] s;
    logic       cout;
    logic       ovf;
  } res_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // 8-bit instances: index 0 -> BPC=1 (K=8), index 1 -> BPC=4 (K=2)
  logic       start8 [2];
  logic       sub8   [2];
  logic       cin8   [2];
  logic [7:0] a8     [2];
  logic [7:0] b8     [2];
  logic       busy8  [2];
  logic       done8  [2];
  logic [7:0] s8     [2];
  logic       cout8  [2];
  logic       ovf8   [2];

  logic       start4, sub4, cin4, busy4, done4, cout4, ovf4;
  logic [3:0] a4, b4, s4;

  int   total = 0;
  int   bad   = 0;
  int   done_cnt = 0;
  res_t exp_q [$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", tag, got, want);
    end
  endtask

  // Reference: plain integer addition; overflow from operand/result signs.
  function automatic res_t model(input int w, input logic [7:0] av, input logic [7:0] bv,
                                 input logic ci, input logic sb);
    logic [8:0] full;
    logic [7:0] mask, aa, bb;
    res_t r;
    mask = 8'((9'd1 << w) - 9'd1);
    aa   = av & mask;
    bb   = (sb ? ~bv : bv) & mask;
    full = {1'b0, aa} + {1'b0, bb} + (sb ? 9'd1 : {8'd0, ci});
    r.s    = full[7:0] & mask;
    r.cout = full[w];
    r.ovf  = (aa[w-1] == bb[w-1]) && (r.s[w-1] != aa[w-1]);
    return r;
  endfunction

  for (genvar g = 0; g < 2; g++) begin : g_w8
    serial_adder_n #(.WIDTH(8), .BITS_PER_CYCLE((g == 0) ? 1 : 4)) u_dut (
      .clk   (clk),
      .rst   (rst),
      .start (start8[g]),
      .sub   (sub8[g]),
      .a     (a8[g]),
      .b     (b8[g]),
      .cin   (cin8[g]),
      .busy  (busy8[g]),
      .done  (done8[g]),
      .s     (s8[g]),
      .cout  (cout8[g]),
      .ovf   (ovf8[g])
    );

    always @(negedge clk) begin
      res_t e;
      if (done8[g]) begin
        done_cnt++;
        if (exp_q.size() == 0) begin
          check($sformatf("w8_%0d_unexpected_done", g), 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          check($sformatf("w8_%0d_s", g), 32'(s8[g]), 32'(e.s));
          check($sformatf("w8_%0d_cout", g), 32'(cout8[g]), 32'(e.cout));
          check($sformatf("w8_%0d_ovf", g), 32'(ovf8[g]), 32'(e.ovf));
        end
      end
    end
  end

  serial_adder_n #(.WIDTH(4), .BITS_PER_CYCLE(1)) u_dut4 (
    .clk   (clk),
    .rst   (rst),
    .start (start4),
    .sub   (sub4),
    .a     (a4),
    .b     (b4),
    .cin   (cin4),
    .busy  (busy4),
    .done  (done4),
    .s     (s4),
    .cout  (cout4),
    .ovf   (ovf4)
  );

  always @(negedge clk) begin
    res_t e;
    if (done4) begin
      done_cnt++;
      if (exp_q.size() == 0) begin
        check("w4_unexpected_done", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check($sformatf("w4_s a=%0h b=%0h", a4, b4), 32'(s4), 32'(e.s[3:0]));
        check("w4_cout", 32'(cout4), 32'(e.cout));
        check("w4_ovf", 32'(ovf4), 32'(e.ovf));
      end
    end
  end

  // One 8-bit operation with per-cycle busy/done/hold checks. poke_at
  // pulses start with other operands mid-RUN; abort_at raises rst.
  task automatic run8(input int d, input logic [7:0] av, input logic [7:0] bv,
                      input logic ci, input logic sb, input int poke_at, input int abort_at);
    int k;
    logic [7:0] s_before;
    k = (d == 0) ? 8 : 2;
    a8[d] = av; b8[d] = bv; cin8[d] = ci; sub8[d] = sb; start8[d] = 1'b1;
    exp_q.push_back(model(8, av, bv, ci, sb));
    s_before = s8[d];
    @(posedge clk);
    for (int c = 1; c <= k; c++) begin
      @(negedge clk);
      start8[d] = 1'b0;
      if (abort_at > 0 && c == abort_at + 1) begin
        rst = 1'b0;
        check("abort_busy", 32'(busy8[d]), 32'd0);
        check("abort_done", 32'(done8[d]), 32'd0);
        check("abort_s", 32'(s8[d]), 32'd0);
        check("abort_cout", 32'(cout8[d]), 32'd0);
        check("abort_ovf", 32'(ovf8[d]), 32'd0);
        exp_q.delete(exp_q.size() - 1);
        return;
      end
      check($sformatf("busy_c%0d", c), 32'(busy8[d]), 32'd1);
      check($sformatf("done_in_run_c%0d", c), 32'(done8[d]), 32'd0);
      check($sformatf("s_hold_c%0d", c), 32'(s8[d]), 32'(s_before));
      if (c == poke_at) begin
        start8[d] = 1'b1; a8[d] = 8'h01; b8[d] = 8'h01; cin8[d] = 1'b0; sub8[d] = 1'b0;
      end
      if (c == abort_at) rst = 1'b1;
    end
    @(negedge clk);
    check("done_pulse", 32'(done8[d]), 32'd1);
    check("busy_in_done", 32'(busy8[d]), 32'd0);
    @(negedge clk);
    check("done_one_cycle", 32'(done8[d]), 32'd0);
  endtask

  // One 4-bit operation; latency is measured with a bounded wait.
  task automatic run4(input logic [3:0] av, input logic [3:0] bv, input logic ci, input logic sb);
    int n;
    a4 = av; b4 = bv; cin4 = ci; sub4 = sb; start4 = 1'b1;
    exp_q.push_back(model(4, {4'd0, av}, {4'd0, bv}, ci, sb));
    @(posedge clk);
    #1 start4 = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!done4 && n < 8);
    check("w4_latency", 32'(n), 32'd5);
  endtask

  initial begin
    int dc;
    for (int i = 0; i < 2; i++) begin
      start8[i] = 1'b0; sub8[i] = 1'b0; cin8[i] = 1'b0; a8[i] = 8'h00; b8[i] = 8'h00;
    end
    start4 = 1'b0; sub4 = 1'b0; cin4 = 1'b0; a4 = 4'h0; b4 = 4'h0;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      check("rst_busy", 32'(busy8[i]), 32'd0);
      check("rst_done", 32'(done8[i]), 32'd0);
      check("rst_s", 32'(s8[i]), 32'd0);
      check("rst_cout", 32'(cout8[i]), 32'd0);
      check("rst_ovf", 32'(ovf8[i]), 32'd0);
    end
    check("rst_busy4", 32'(busy4), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    run8(0, 8'h5A, 8'h3C, 1'b0, 1'b0, 0, 0);
    run8(0, 8'hFF, 8'h01, 1'b1, 1'b0, 0, 0);
    run8(0, 8'h10, 8'h20, 1'b0, 1'b1, 0, 0);
    run8(0, 8'hC3, 8'h2B, 1'b1, 1'b0, 4, 0);

    // Start held high through done: second op accepted in the done cycle.
    a8[0] = 8'h7F; b8[0] = 8'h01; cin8[0] = 1'b0; sub8[0] = 1'b0; start8[0] = 1'b1;
    exp_q.push_back(model(8, 8'h7F, 8'h01, 1'b0, 1'b0));
    @(posedge clk);
    @(negedge clk);
    a8[0] = 8'h33; b8[0] = 8'h44; sub8[0] = 1'b1;
    exp_q.push_back(model(8, 8'h33, 8'h44, 1'b0, 1'b1));
    for (int c = 2; c <= 9; c++) @(negedge clk);
    check("b2b_first_done", 32'(done8[0]), 32'd1);
    @(negedge clk);
    start8[0] = 1'b0;
    for (int c = 10; c <= 17; c++) begin
      check($sformatf("b2b_busy_c%0d", c), 32'(busy8[0]), 32'd1);
      @(negedge clk);
    end
    check("b2b_second_done", 32'(done8[0]), 32'd1);
    @(negedge clk);

    // Reset mid-RUN, then confirm no completion follows and a fresh op works.
    run8(0, 8'h77, 8'h11, 1'b0, 1'b0, 0, 4);
    dc = done_cnt;
    repeat (12) @(negedge clk);
    check("abort_no_done", 32'(done_cnt), 32'(dc));
    check("abort_s_stays", 32'(s8[0]), 32'd0);
    run8(0, 8'h12, 8'h34, 1'b1, 1'b0, 0, 0);

    run8(1, 8'h80, 8'h80, 1'b0, 1'b0, 0, 0);
    run8(1, 8'h7F, 8'h80, 1'b1, 1'b1, 0, 0);
    run8(1, 8'h00, 8'h01, 1'b0, 1'b1, 0, 0);

    for (int sb = 0; sb < 2; sb++)
      for (int ci = 0; ci < 2 - sb; ci++)
        for (int av = 0; av < 16; av++)
          for (int bv = 0; bv < 16; bv++)
            run4(4'(av), 4'(bv), 1'(ci), 1'(sb));
    @(negedge clk);

    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Watchdog so the bench always terminates.
  initial begin
    #500000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

endmodule
